// File: rtl/dual_biquad_pkg.sv
// Shared types and constants for the dual biquad coefficient path: loader FSM
// states, host shadow addresses and the default coefficient width.
package dual_biquad_pkg;

    localparam int CDAT_BITS_DEFAULT = 18;

    localparam logic ADR_HIGH = 1'b0;
    localparam logic ADR_LOW  = 1'b1;

    // Wide enough for the largest legal hold length (3).
    localparam int HOLD_W = $clog2(3) + 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LD_HI,
        ST_H1,
        ST_XFER,
        ST_H2,
        ST_LD_LO,
        ST_H3,
        ST_UPD,
        ST_H4,
        ST_DONE
    } ld_state_e;

endpackage

// File: rtl/biquad8_coeff_loader.sv
// Coefficient loader: two host shadow registers and an FSM that plays a snapshot
// of them through the B1/B2 cascade of the incremental biquad stage.
module biquad8_coeff_loader
    import dual_biquad_pkg::*;
#(
    parameter int CDAT_BITS   = CDAT_BITS_DEFAULT,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 host_wr_i,
    input  logic                 host_adr_i,
    input  logic [CDAT_BITS-1:0] host_dat_i,
    input  logic                 commit_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 coeff_adr_o,
    output logic                 coeff_wr_o,
    output logic                 coeff_update_o,
    output logic [CDAT_BITS-1:0] coeff_dat_o
);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 3) begin : g_bad_hold
        $error("biquad8_coeff_loader: HOLD_CYCLES must be in 1..3");
    end

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    ld_state_e             state_q, state_d;
    logic [HOLD_W-1:0]     hold_cnt_q;
    logic                  pending_q;
    logic [CDAT_BITS-1:0]  shadow_hi_q, shadow_lo_q;
    logic [CDAT_BITS-1:0]  snap_hi_q, snap_lo_q;
    logic                  hold_last;
    logic                  in_hold;
    logic                  restart;
    logic                  take_snap;

    // Next-state logic; the hold states each wait HOLD_CYCLES cycles.
    always_comb begin
        state_d   = state_q;
        hold_last = (hold_cnt_q == HOLD_LAST);
        in_hold   = (state_q == ST_H1) || (state_q == ST_H2) ||
                    (state_q == ST_H3) || (state_q == ST_H4);
        restart   = (state_q == ST_DONE) && (pending_q || commit_i);
        take_snap = ((state_q == ST_IDLE) && commit_i) || restart;
        case (state_q)
            ST_IDLE:  if (commit_i) state_d = ST_LD_HI;
            ST_LD_HI: state_d = ST_H1;
            ST_H1:    if (hold_last) state_d = ST_XFER;
            ST_XFER:  state_d = ST_H2;
            ST_H2:    if (hold_last) state_d = ST_LD_LO;
            ST_LD_LO: state_d = ST_H3;
            ST_H3:    if (hold_last) state_d = ST_UPD;
            ST_UPD:   state_d = ST_H4;
            ST_H4:    if (hold_last) state_d = ST_DONE;
            ST_DONE:  state_d = restart ? ST_LD_HI : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Control state, shadows and snapshots; the snapshot sees pre-write shadows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hold_cnt_q  <= '0;
            pending_q   <= 1'b0;
            shadow_hi_q <= '0;
            shadow_lo_q <= '0;
            snap_hi_q   <= '0;
            snap_lo_q   <= '0;
        end else begin
            state_q <= state_d;
            if (in_hold && !hold_last) hold_cnt_q <= hold_cnt_q + 1'b1;
            else                       hold_cnt_q <= '0;
            if (state_q == ST_DONE)                    pending_q <= 1'b0;
            else if (commit_i && state_q != ST_IDLE)   pending_q <= 1'b1;
            if (host_wr_i && host_adr_i == ADR_HIGH)   shadow_hi_q <= host_dat_i;
            if (host_wr_i && host_adr_i == ADR_LOW)    shadow_lo_q <= host_dat_i;
            if (take_snap) begin
                snap_hi_q <= shadow_hi_q;
                snap_lo_q <= shadow_lo_q;
            end
        end
    end

    // Registered outputs; data only moves on a write strobe and holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            coeff_adr_o    <= 1'b0;
            coeff_wr_o     <= 1'b0;
            coeff_update_o <= 1'b0;
            coeff_dat_o    <= '0;
        end else begin
            busy_o         <= (state_d != ST_IDLE);
            done_o         <= (state_q == ST_DONE);
            coeff_adr_o    <= (state_q == ST_XFER);
            coeff_wr_o     <= (state_q == ST_LD_HI) || (state_q == ST_XFER) ||
                              (state_q == ST_LD_LO);
            coeff_update_o <= (state_q == ST_UPD);
            if (state_q == ST_LD_HI || state_q == ST_XFER) coeff_dat_o <= snap_hi_q;
            else if (state_q == ST_LD_LO)                  coeff_dat_o <= snap_lo_q;
        end
    end

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// Self-checking bench for biquad8_coeff_loader: per-cycle traces against a
// latency model, plus a behavioural B1/B2 cascade for the loaded coefficients.
module tb_biquad8_coeff_loader;
    import dual_biquad_pkg::*;

    localparam int W    = 18;
    localparam int NCAP = 64;
    localparam int VW   = W + 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         host_wr_i = 1'b0;
    logic         host_adr_i = 1'b0;
    logic [W-1:0] host_dat_i = '0;
    logic         commit_i = 1'b0;

    logic         busy1, done1, adr1, wr1, upd1;
    logic [W-1:0] dat1;
    logic         busy3, done3, adr3, wr3, upd3;
    logic [W-1:0] dat3;

    logic          sel3 = 1'b0;
    logic [VW-1:0] vec1, vec3, obs_vec;

    int total = 0;
    int bad   = 0;

    logic [4:0]    exp_ctl  [NCAP];
    logic [W-1:0]  exp_sdat [NCAP];
    logic [VW-1:0] exp_vec  [NCAP];
    logic [VW-1:0] cap_vec  [NCAP];

    // Host-visible shadow contents, indexed by host address.
    logic [W-1:0] sh [2];

    always #5 clk = ~clk;

    biquad8_coeff_loader #(.CDAT_BITS(W), .HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .host_wr_i(host_wr_i), .host_adr_i(host_adr_i),
        .host_dat_i(host_dat_i), .commit_i(commit_i), .busy_o(busy1), .done_o(done1),
        .coeff_adr_o(adr1), .coeff_wr_o(wr1), .coeff_update_o(upd1), .coeff_dat_o(dat1)
    );

    biquad8_coeff_loader #(.CDAT_BITS(W), .HOLD_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .host_wr_i(host_wr_i), .host_adr_i(host_adr_i),
        .host_dat_i(host_dat_i), .commit_i(commit_i), .busy_o(busy3), .done_o(done3),
        .coeff_adr_o(adr3), .coeff_wr_o(wr3), .coeff_update_o(upd3), .coeff_dat_o(dat3)
    );

    assign vec1    = {busy1, wr1, adr1, upd1, done1, dat1};
    assign vec3    = {busy3, wr3, adr3, upd3, done3, dat3};
    assign obs_vec = sel3 ? vec3 : vec1;

    // Filter cascade: registered clock enables, adr=0 loads low B1 from data,
    // adr=1 shifts low B1 into high B1, update copies both B1 into B2.
    logic [W-1:0] lo_b1 = '0, hi_b1 = '0, lo_b2 = '0, hi_b2 = '0;
    logic         ce_wr = 1'b0, ce_adr = 1'b0, ce_upd = 1'b0;
    always @(posedge clk) begin
        ce_wr  <= wr1;
        ce_adr <= adr1;
        ce_upd <= upd1;
        if (ce_wr) begin
            if (ce_adr) hi_b1 <= lo_b1;
            else        lo_b1 <= dat1;
        end
        if (ce_upd) begin
            lo_b2 <= lo_b1;
            hi_b2 <= hi_b1;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [VW-1:0] obs,
                                input logic [VW-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic clear_expect();
        for (int c = 0; c < NCAP; c++) begin
            exp_ctl[c]  = '0;
            exp_sdat[c] = '0;
        end
    endtask

    // One load sequence snapshotted at the end of cycle 'start'; ctl = {busy,wr,adr,upd,done}.
    task automatic add_sequence(input int start, input int h,
                                input logic [W-1:0] hi, input logic [W-1:0] lo);
        int t_x, t_l, t_u, t_d;
        t_x = start + 3 + h;
        t_l = start + 4 + 2 * h;
        t_u = start + 5 + 3 * h;
        t_d = start + 6 + 4 * h;
        for (int t = start + 1; t < t_d && t < NCAP; t++) exp_ctl[t][4] = 1'b1;
        exp_ctl[start + 2][3] = 1'b1;
        exp_sdat[start + 2]   = hi;
        if (t_x < NCAP) begin exp_ctl[t_x][3] = 1'b1; exp_ctl[t_x][2] = 1'b1; exp_sdat[t_x] = hi; end
        if (t_l < NCAP) begin exp_ctl[t_l][3] = 1'b1; exp_sdat[t_l] = lo; end
        if (t_u < NCAP) exp_ctl[t_u][1] = 1'b1;
        if (t_d < NCAP) exp_ctl[t_d][0] = 1'b1;
    endtask

    task automatic finalize_expect(input logic [W-1:0] prev_dat);
        logic [W-1:0] cur;
        cur = prev_dat;
        for (int c = 1; c < NCAP; c++) begin
            if (exp_ctl[c][3]) cur = exp_sdat[c];
            exp_vec[c] = {exp_ctl[c], cur};
        end
    endtask

    // Cycle 0 is the first driven cycle; outputs are captured at the negedge of cycles 1..n.
    task automatic apply_stimulus(input int n, input logic [63:0] commit_mask,
                                  input int wr_cycle, input logic wr_adr,
                                  input logic [W-1:0] wr_dat);
        for (int c = 0; c <= n; c++) begin
            @(negedge clk);
            if (c > 0) cap_vec[c] = obs_vec;
            commit_i   = commit_mask[c];
            host_wr_i  = (c == wr_cycle);
            host_adr_i = wr_adr;
            host_dat_i = wr_dat;
        end
        commit_i  = 1'b0;
        host_wr_i = 1'b0;
    endtask

    task automatic check_trace(input string tag, input int n);
        for (int c = 1; c <= n; c++)
            check_output($sformatf("%s c%0d", tag, c), cap_vec[c], exp_vec[c]);
    endtask

    task automatic host_write(input logic adr, input logic [W-1:0] dat);
        @(negedge clk);
        host_wr_i  = 1'b1;
        host_adr_i = adr;
        host_dat_i = dat;
        sh[adr]    = dat;
        @(negedge clk);
        host_wr_i = 1'b0;
    endtask

    task automatic check_b2(input string tag);
        check_output({tag, " lo_b2"}, {5'b0, lo_b2}, {5'b0, sh[ADR_LOW]});
        check_output({tag, " hi_b2"}, {5'b0, hi_b2}, {5'b0, sh[ADR_HIGH]});
    endtask

    initial begin
        logic [W-1:0] prev;
        logic [W-1:0] keep_lo, keep_hi;
        logic [63:0]  mask;
        sh[0] = '0;
        sh[1] = '0;

        repeat (3) @(negedge clk);
        check_output("reset dut1", vec1, '0);
        check_output("reset dut3", vec3, '0);
        rst_n = 1'b1;

        $display("[TB] basic load");
        host_write(ADR_HIGH, 18'h00123);
        host_write(ADR_LOW, 18'h3FF00);
        clear_expect();
        add_sequence(0, 1, sh[ADR_HIGH], sh[ADR_LOW]);
        finalize_expect('0);
        apply_stimulus(12, 64'h1, -1, 1'b0, '0);
        check_trace("basic", 12);
        check_b2("basic");

        $display("[TB] host write during busy");
        prev = sh[ADR_LOW];
        clear_expect();
        add_sequence(0, 1, sh[ADR_HIGH], sh[ADR_LOW]);
        finalize_expect(prev);
        apply_stimulus(12, 64'h1, 3, ADR_HIGH, 18'h00555);
        check_trace("wrbusy", 12);
        check_b2("wrbusy");
        sh[ADR_HIGH] = 18'h00555;
        clear_expect();
        add_sequence(0, 1, sh[ADR_HIGH], sh[ADR_LOW]);
        finalize_expect(prev);
        apply_stimulus(12, 64'h1, -1, 1'b0, '0);
        check_trace("wrnext", 12);
        check_b2("wrnext");

        $display("[TB] random coefficients");
        for (int r = 0; r < 4; r++) begin
            prev = sh[ADR_LOW];
            host_write(1'($urandom_range(1)), W'($urandom));
            host_write(1'($urandom_range(1)), W'($urandom));
            clear_expect();
            add_sequence(0, 1, sh[ADR_HIGH], sh[ADR_LOW]);
            finalize_expect(prev);
            apply_stimulus(12, 64'h1, -1, 1'b0, '0);
            check_trace($sformatf("rand%0d", r), 12);
            check_b2($sformatf("rand%0d", r));
        end

        $display("[TB] commits while busy");
        prev = sh[ADR_LOW];
        clear_expect();
        add_sequence(0, 1, sh[ADR_HIGH], sh[ADR_LOW]);
        add_sequence(9, 1, sh[ADR_HIGH], sh[ADR_LOW]);
        finalize_expect(prev);
        mask = 64'h0;
        mask[0] = 1'b1;
        mask[2] = 1'b1;
        mask[5] = 1'b1;
        apply_stimulus(21, mask, -1, 1'b0, '0);
        check_trace("collapse", 21);
        check_b2("collapse");

        $display("[TB] async reset mid-sequence");
        keep_lo = lo_b2;
        keep_hi = hi_b2;
        prev = sh[ADR_LOW];
        clear_expect();
        add_sequence(0, 1, sh[ADR_HIGH], sh[ADR_LOW]);
        finalize_expect(prev);
        apply_stimulus(5, 64'h1, -1, 1'b0, '0);
        check_trace("prereset", 5);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_output("async reset outputs", vec1, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sh[0] = '0;
        sh[1] = '0;
        clear_expect();
        finalize_expect('0);
        apply_stimulus(6, 64'h0, -1, 1'b0, '0);
        check_trace("postreset idle", 6);
        check_output("b2 lo kept", {5'b0, lo_b2}, {5'b0, keep_lo});
        check_output("b2 hi kept", {5'b0, hi_b2}, {5'b0, keep_hi});
        clear_expect();
        add_sequence(0, 1, '0, '0);
        finalize_expect('0);
        apply_stimulus(12, 64'h1, -1, 1'b0, '0);
        check_trace("zeroload", 12);
        check_b2("zeroload");

        $display("[TB] hold cycles = 3");
        repeat (10) @(negedge clk);
        sel3 = 1'b1;
        host_write(ADR_HIGH, W'($urandom));
        host_write(ADR_LOW, W'($urandom));
        clear_expect();
        add_sequence(0, 3, sh[ADR_HIGH], sh[ADR_LOW]);
        finalize_expect('0);
        apply_stimulus(20, 64'h1, -1, 1'b0, '0);
        check_trace("hold3", 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
